// File: rtl/msrv32_alu_issue.sv
// ALU issue stage: decodes OP/OP-IMM/LUI/AUIPC into ALU operands and buffers them behind a valid/ready pair.
// Define MSRV32_ALU_ISSUE_SKID_EN for the 2-entry skid buffer with a registered in_ready_out.
module msrv32_alu_issue #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             ms_riscv32_mp_clk_in,
    input  logic             ms_riscv32_mp_rst_n_in,
    input  logic [31:0]      instr_in,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] rs1_in,
    input  logic [WIDTH-1:0] rs2_in,
    input  logic             in_valid_in,
    output logic             in_ready_out,
    output logic [WIDTH-1:0] op_1_out,
    output logic [WIDTH-1:0] op_2_out,
    output logic [3:0]       opcode_out,
    output logic [4:0]       rd_addr_out,
    output logic             wr_en_out,
    output logic             illegal_out,
    output logic             out_valid_out,
    input  logic             out_ready_in
);

    localparam int unsigned PW = 2 * WIDTH + 11;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] F7_ZERO    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [3:0] ALU_ADD    = 4'b0000;

    logic [6:0]       opc;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [4:0]       rd;
    logic             legal;
    logic [WIDTH-1:0] op1;
    logic [WIDTH-1:0] op2;
    logic [3:0]       alu_op;
    logic [PW-1:0]    dec;
    logic [PW-1:0]    main_q;
    logic             main_v;

    assign opc = instr_in[6:0];
    assign rd  = instr_in[11:7];
    assign f3  = instr_in[14:12];
    assign f7  = instr_in[31:25];

    // Instruction decode; anything unrecognised collapses to an illegal ADD 0,0.
    always_comb begin
        legal  = 1'b0;
        op1    = '0;
        op2    = '0;
        alu_op = ALU_ADD;
        case (opc)
            OPC_OP: begin
                op1    = rs1_in;
                op2    = rs2_in;
                alu_op = {instr_in[30], f3};
                legal  = (f7 == F7_ZERO) ||
                         ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                op1 = rs1_in;
                if (f3 == 3'b001) begin
                    op2    = WIDTH'(instr_in[24:20]);
                    alu_op = {1'b0, f3};
                    legal  = (f7 == F7_ZERO);
                end else if (f3 == 3'b101) begin
                    op2    = WIDTH'(instr_in[24:20]);
                    alu_op = {instr_in[30], f3};
                    legal  = (f7 == F7_ZERO) || (f7 == F7_ALT);
                end else begin
                    op2    = WIDTH'($signed(instr_in[31:20]));
                    alu_op = {1'b0, f3};
                    legal  = 1'b1;
                end
            end
            OPC_LUI: begin
                op2   = WIDTH'($signed({instr_in[31:12], 12'b0}));
                legal = 1'b1;
            end
            OPC_AUIPC: begin
                op1   = pc_in;
                op2   = WIDTH'($signed({instr_in[31:12], 12'b0}));
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            op1    = '0;
            op2    = '0;
            alu_op = ALU_ADD;
        end
        dec = {op1, op2, alu_op, (legal ? rd : 5'd0), (legal && (rd != 5'd0)), ~legal};
    end

`ifdef MSRV32_ALU_ISSUE_SKID_EN
    logic [PW-1:0] skid_q;
    logic          skid_v;
    logic          accept;
    logic          drain;

    assign in_ready_out = ~skid_v;
    assign accept       = in_valid_in & ~skid_v;
    assign drain        = main_v & out_ready_in;

    // Main/skid pair: skid only fills when main is occupied and stalled.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            main_q <= '0;
            main_v <= 1'b0;
            skid_q <= '0;
            skid_v <= 1'b0;
        end else if (skid_v) begin
            if (drain) begin
                main_q <= skid_q;
                skid_v <= 1'b0;
            end
        end else if (accept) begin
            if (!main_v || drain) begin
                main_q <= dec;
                main_v <= 1'b1;
            end else begin
                skid_q <= dec;
                skid_v <= 1'b1;
            end
        end else if (drain) begin
            main_v <= 1'b0;
        end
    end
`else
    assign in_ready_out = ~main_v | out_ready_in;

    // Single output register, refilled in the same edge it drains.
    always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            main_q <= '0;
            main_v <= 1'b0;
        end else if (in_ready_out) begin
            main_v <= in_valid_in;
            if (in_valid_in) begin
                main_q <= dec;
            end
        end
    end
`endif

    assign {op_1_out, op_2_out, opcode_out, rd_addr_out, wr_en_out, illegal_out} = main_q;
    assign out_valid_out = main_v;

endmodule

// File: tb/tb_msrv32_alu_issue.sv
// Self-checking bench for msrv32_alu_issue: vector table, scoreboard monitor, backpressure and reset sequences.
module tb_msrv32_alu_issue;

    localparam int unsigned W  = 32;
    localparam int unsigned PW = 2 * W + 11;
    localparam int unsigned NV = 14;

    typedef struct {
        logic [31:0]   instr;
        logic [W-1:0]  pc;
        logic [W-1:0]  rs1;
        logic [W-1:0]  rs2;
        logic [PW-1:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   instr;
    logic [W-1:0]  pc, rs1, rs2;
    logic          in_valid, in_ready;
    logic [W-1:0]  op_1, op_2;
    logic [3:0]    opcode;
    logic [4:0]    rd_addr;
    logic          wr_en, illegal, out_valid, out_ready;

    vec_t          tbl [NV];
    logic [PW-1:0] sb [$];
    logic [PW-1:0] cur_exp;
    logic [PW-1:0] got;
    int            pass_cnt = 0;
    int            chk_cnt  = 0;

    assign got = {op_1, op_2, opcode, rd_addr, wr_en, illegal};

    msrv32_alu_issue #(.WIDTH(W)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .instr_in               (instr),
        .pc_in                  (pc),
        .rs1_in                 (rs1),
        .rs2_in                 (rs2),
        .in_valid_in            (in_valid),
        .in_ready_out           (in_ready),
        .op_1_out               (op_1),
        .op_2_out               (op_2),
        .opcode_out             (opcode),
        .rd_addr_out            (rd_addr),
        .wr_en_out              (wr_en),
        .illegal_out            (illegal),
        .out_valid_out          (out_valid),
        .out_ready_in           (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    function automatic vec_t mk(input logic [31:0] i, input logic [W-1:0] p, input logic [W-1:0] a,
                                input logic [W-1:0] b, input logic [W-1:0] o1, input logic [W-1:0] o2,
                                input logic [3:0] opc, input logic [4:0] rd, input logic wr, input logic ill);
        vec_t v;
        v.instr = i;
        v.pc    = p;
        v.rs1   = a;
        v.rs2   = b;
        v.exp   = {o1, o2, opc, rd, wr, ill};
        return v;
    endfunction

    task automatic chk(input string name, input logic [PW-1:0] act, input logic [PW-1:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s got=%h exp=%h", name, act, req);
    endtask

    task automatic drive(input int i);
        instr    = tbl[i].instr;
        pc       = tbl[i].pc;
        rs1      = tbl[i].rs1;
        rs2      = tbl[i].rs2;
        cur_exp  = tbl[i].exp;
        in_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare the head entry while it is presented, pop it on transfer, push new accepts.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    chk_cnt++;
                    $display("FAIL unexpected_output got=%h exp=none", got);
                end else begin
                    chk(out_ready ? "transfer" : "stall_hold", got, sb[0]);
                    if (out_ready) void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(cur_exp);
        end
    end

    initial begin
        tbl[0]  = mk(32'h002081B3, 32'h0,   32'd5,        32'd7, 32'd5,        32'd7,        4'b0000, 5'd3,  1'b1, 1'b0);
        tbl[1]  = mk(32'h40435293, 32'h0,   32'h80000000, 32'd0, 32'h80000000, 32'd4,        4'b1101, 5'd5,  1'b1, 1'b0);
        tbl[2]  = mk(32'h00000013, 32'h0,   32'd0,        32'd0, 32'd0,        32'd0,        4'b0000, 5'd0,  1'b0, 1'b0);
        tbl[3]  = mk(32'h12345097, 32'h100, 32'd0,        32'd0, 32'h100,      32'h12345000, 4'b0000, 5'd1,  1'b1, 1'b0);
        tbl[4]  = mk(32'h0000007F, 32'h40,  32'd9,        32'd9, 32'd0,        32'd0,        4'b0000, 5'd0,  1'b0, 1'b1);
        tbl[5]  = mk(32'h40208233, 32'h0,   32'd10,       32'd3, 32'd10,       32'd3,        4'b1000, 5'd4,  1'b1, 1'b0);
        tbl[6]  = mk(32'h4020C233, 32'h0,   32'd10,       32'd3, 32'd0,        32'd0,        4'b0000, 5'd0,  1'b0, 1'b1);
        tbl[7]  = mk(32'hFFF08393, 32'h0,   32'd9,        32'd1, 32'd9,        32'hFFFFFFFF, 4'b0000, 5'd7,  1'b1, 1'b0);
        tbl[8]  = mk(32'hABCDE537, 32'h80,  32'h55,       32'd1, 32'd0,        32'hABCDE000, 4'b0000, 5'd10, 1'b1, 1'b0);
        tbl[9]  = mk(32'h01F19113, 32'h0,   32'd1,        32'd6, 32'd1,        32'd31,       4'b0001, 5'd2,  1'b1, 1'b0);
        tbl[10] = mk(32'h40119113, 32'h0,   32'd1,        32'd6, 32'd0,        32'd0,        4'b0000, 5'd0,  1'b0, 1'b1);
        tbl[11] = mk(32'h0052B313, 32'h0,   32'd2,        32'd6, 32'd2,        32'd5,        4'b0011, 5'd6,  1'b1, 1'b0);
        tbl[12] = mk(32'h0034D413, 32'h0,   32'hF0,       32'd6, 32'hF0,       32'd3,        4'b0101, 5'd8,  1'b1, 1'b0);
        tbl[13] = mk(32'h4000C093, 32'h0,   32'd3,        32'd6, 32'd3,        32'h400,      4'b0100, 5'd1,  1'b1, 1'b0);

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; pc = '0; rs1 = '0; rs2 = '0; cur_exp = '0;
        #12;
        chk("reset_outputs", {out_valid, got}, '0);
        chk("reset_in_ready", PW'(in_ready), PW'(1));
        #11 rst_n = 1'b1;
        step();
        chk("first_edge_in_ready", PW'(in_ready), PW'(1));

        // Directed vectors with one-cycle latency.
        out_ready = 1'b1;
        for (int i = 0; i < int'(NV); i++) begin
            drive(i);
            step();
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("latency_vec%0d", i), PW'(out_valid), PW'(1));
            step();
        end

        // Backpressure: fill the buffer, then release with no bubble.
        out_ready = 1'b0;
        drive(0);
        step();
        drive(5);
`ifdef MSRV32_ALU_ISSUE_SKID_EN
        step();
        drive(8);
        chk("skid_full_in_ready", PW'(in_ready), PW'(0));
        step();
        chk("skid_stall", PW'({out_valid, in_ready}), PW'(2'b10));
        out_ready = 1'b1;
        @(negedge clk);
        chk("release_a", PW'({out_valid, in_ready}), PW'(2'b10));
        @(negedge clk);
        chk("release_b", PW'({out_valid, in_ready}), PW'(2'b11));
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("release_c", PW'(out_valid), PW'(1));
`else
        chk("full_in_ready", PW'(in_ready), PW'(0));
        step();
        chk("stall", PW'({out_valid, in_ready}), PW'(2'b10));
        out_ready = 1'b1;
        #1;
        chk("release_ready", PW'(in_ready), PW'(1));
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("release_b", PW'(out_valid), PW'(1));
`endif
        step();

        // Random traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) != 0) drive(int'($urandom_range(0, NV - 1)));
            else in_valid = 1'b0;
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (sb.size() != 0 || out_valid); c++) step();
        chk("drain_empty", PW'({sb.size() != 0, out_valid}), PW'(0));

        // Reset with entries buffered.
        out_ready = 1'b0;
        drive(1);
        step();
        drive(3);
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_outputs", {out_valid, got}, '0);
        chk("midreset_in_ready", PW'(in_ready), PW'(1));
        sb.delete();
        step();
        step();
        #3 rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("post_reset_in_ready", PW'(in_ready), PW'(1));
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("no_stale_%0d", c), PW'(out_valid), PW'(0));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
